// File: rtl/bcd_timer.sv
// mm:ss BCD stopwatch/timer with up/down count, field adjust, rollover pulse and zero flag.
// 1 Hz and adjust-rate pulses are plain clock enables; everything runs on clk.
module bcd_timer #(
    parameter int unsigned MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       tick_adj,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    input  logic       dir,
    output logic [3:0] sec_1s_out,
    output logic [3:0] sec_10s_out,
    output logic [3:0] min_1s_out,
    output logic [3:0] min_10s_out,
    output logic       rollover,
    output logic       at_zero
);

    if (MIN_MAX < 1 || MIN_MAX > 99) begin : g_min_max_check
        $error("bcd_timer: MIN_MAX must be in 1..99");
    end

    localparam logic [3:0] MT = 4'(MIN_MAX / 10);
    localparam logic [3:0] MO = 4'(MIN_MAX % 10);

    logic [3:0] s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
    logic       roll_q, roll_d, zero_q, zero_d;

    logic       step;
    logic       s_wrap_up, s_wrap_dn, m_at_max, m_at_zero;
    logic [3:0] s_up1, s_up10, s_dn1, s_dn10;
    logic [3:0] m_up1, m_up10, m_dn1, m_dn10;

    // Only the enable belonging to the current mode can cause a step.
    assign step = !pause && (adj ? tick_adj : tick);

    always_comb begin
        s_wrap_up = (s10_q == 4'd5) && (s1_q == 4'd9);
        s_wrap_dn = (s10_q == 4'd0) && (s1_q == 4'd0);
        m_at_max  = (m10_q == MT) && (m1_q == MO);
        m_at_zero = (m10_q == 4'd0) && (m1_q == 4'd0);

        s_up1  = (s1_q == 4'd9) ? 4'd0 : s1_q + 4'd1;
        s_up10 = (s1_q == 4'd9) ? ((s10_q == 4'd5) ? 4'd0 : s10_q + 4'd1) : s10_q;
        s_dn1  = (s1_q == 4'd0) ? 4'd9 : s1_q - 4'd1;
        s_dn10 = (s1_q == 4'd0) ? ((s10_q == 4'd0) ? 4'd5 : s10_q - 4'd1) : s10_q;

        m_up1  = m_at_max ? 4'd0 : ((m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1);
        m_up10 = m_at_max ? 4'd0 : ((m1_q == 4'd9) ? m10_q + 4'd1 : m10_q);
        m_dn1  = m_at_zero ? MO : ((m1_q == 4'd0) ? 4'd9 : m1_q - 4'd1);
        m_dn10 = m_at_zero ? MT : ((m1_q == 4'd0) ? m10_q - 4'd1 : m10_q);
    end

    always_comb begin
        s1_d   = s1_q;
        s10_d  = s10_q;
        m1_d   = m1_q;
        m10_d  = m10_q;
        roll_d = 1'b0;
        if (step) begin
            if (adj) begin
                // Adjust touches only the selected field; no carry between fields.
                if (sel) begin
                    s1_d  = dir ? s_dn1 : s_up1;
                    s10_d = dir ? s_dn10 : s_up10;
                end else begin
                    m1_d  = dir ? m_dn1 : m_up1;
                    m10_d = dir ? m_dn10 : m_up10;
                end
            end else if (!dir) begin
                s1_d  = s_up1;
                s10_d = s_up10;
                if (s_wrap_up) begin
                    m1_d  = m_up1;
                    m10_d = m_up10;
                end
                roll_d = s_wrap_up && m_at_max;
            end else begin
                s1_d  = s_dn1;
                s10_d = s_dn10;
                if (s_wrap_dn) begin
                    m1_d  = m_dn1;
                    m10_d = m_dn10;
                end
                roll_d = s_wrap_dn && m_at_zero;
            end
        end
        zero_d = (s1_d == 4'd0) && (s10_d == 4'd0) && (m1_d == 4'd0) && (m10_d == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 4'd0;
            s10_q  <= 4'd0;
            m1_q   <= 4'd0;
            m10_q  <= 4'd0;
            roll_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s10_q  <= s10_d;
            m1_q   <= m1_d;
            m10_q  <= m10_d;
            roll_q <= roll_d;
            zero_q <= zero_d;
        end
    end

    assign sec_1s_out  = s1_q;
    assign sec_10s_out = s10_q;
    assign min_1s_out  = m1_q;
    assign min_10s_out = m10_q;
    assign rollover    = roll_q;
    assign at_zero     = zero_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Scoreboard bench for bcd_timer: MIN_MAX=59 and MIN_MAX=15 instances, directed vectors.
// Each stimulus cycle queues its expectation; a monitor pops and compares after every edge.
module tb_bcd_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, tick, tick_adj, pause, adj, sel, dir;
    logic [3:0] a_s1, a_s10, a_m1, a_m10, b_s1, b_s10, b_m1, b_m10;
    logic a_ro, a_z, b_ro, b_z;

    bcd_timer #(.MIN_MAX(59)) dut_a (
        .clk(clk), .rst(rst_a), .tick(tick), .tick_adj(tick_adj), .pause(pause), .adj(adj),
        .sel(sel), .dir(dir), .sec_1s_out(a_s1), .sec_10s_out(a_s10), .min_1s_out(a_m1),
        .min_10s_out(a_m10), .rollover(a_ro), .at_zero(a_z)
    );

    bcd_timer #(.MIN_MAX(15)) dut_b (
        .clk(clk), .rst(rst_b), .tick(tick), .tick_adj(tick_adj), .pause(pause), .adj(adj),
        .sel(sel), .dir(dir), .sec_1s_out(b_s1), .sec_10s_out(b_s10), .min_1s_out(b_m1),
        .min_10s_out(b_m10), .rollover(b_ro), .at_zero(b_z)
    );

    typedef struct {
        string       nm;
        bit          which;   // 0 = dut_a (59), 1 = dut_b (15)
        bit          chk_dig;
        logic [15:0] dig;     // {m10, m1, s10, s1}
        bit          chk_ro;
        logic        ro;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   cur = 1'b0;

    // Drive one cycle of stimulus on the falling edge and queue what the next edge should produce.
    task automatic cyc(input string nm, input logic r, input logic tk, input logic ta,
                       input logic p, input logic a, input logic s, input logic d,
                       input bit chk_dig, input logic [15:0] dig, input bit chk_ro,
                       input logic ro);
        exp_t e;
        @(negedge clk);
        rst_a    = (cur == 1'b0) ? r : 1'b1;
        rst_b    = (cur == 1'b1) ? r : 1'b1;
        tick     = tk;
        tick_adj = ta;
        pause    = p;
        adj      = a;
        sel      = s;
        dir      = d;
        e.nm = nm; e.which = cur; e.chk_dig = chk_dig; e.dig = dig;
        e.chk_ro = chk_ro; e.ro = ro;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic do_reset(input string nm);
        cyc(nm, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 1, 0);
    endtask

    // n plain up ticks in normal mode; only rollover is checked per tick.
    task automatic up_ticks(input string nm, input int n);
        for (int i = 0; i < n; i++) cyc(nm, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [15:0] got;
            logic        gro, gz;
            e   = exp_q.pop_front();
            got = e.which ? {b_m10, b_m1, b_s10, b_s1} : {a_m10, a_m1, a_s10, a_s1};
            gro = e.which ? b_ro : a_ro;
            gz  = e.which ? b_z : a_z;
            if (e.chk_dig) begin
                total++;
                if (got !== e.dig) begin
                    bad++;
                    $display("FAIL %s digits: got %h want %h", e.nm, got, e.dig);
                end
                total++;
                if (gz !== (e.dig == 16'h0)) begin
                    bad++;
                    $display("FAIL %s at_zero: got %b want %b", e.nm, gz, e.dig == 16'h0);
                end
            end
            if (e.chk_ro) begin
                total++;
                if (gro !== e.ro) begin
                    bad++;
                    $display("FAIL %s rollover: got %b want %b", e.nm, gro, e.ro);
                end
            end
        end
    end

    initial begin
        rst_a = 1; rst_b = 1; tick = 0; tick_adj = 0; pause = 0; adj = 0; sel = 0; dir = 0;
        cur = 0;
        do_reset("reset");

        // 1: full hour up on MIN_MAX=59
        for (int i = 1; i <= 3600; i++) begin
            if (i == 1)         cyc("up1", 0, 1, 0, 0, 0, 0, 0, 1, 16'h0001, 1, 0);
            else if (i == 60)   cyc("up60", 0, 1, 0, 0, 0, 0, 0, 1, 16'h0100, 1, 0);
            else if (i == 3599) cyc("up3599", 0, 1, 0, 0, 0, 0, 0, 1, 16'h5959, 1, 0);
            else if (i == 3600) cyc("up3600", 0, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 1, 1);
            else                cyc("up_ro", 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0);
        end
        cyc("up_ro_clear", 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 1, 0);

        // 2: count down wraps from 00:00 to 59:59
        do_reset("reset2");
        cyc("dn_wrap", 0, 1, 0, 0, 0, 0, 1, 1, 16'h5959, 1, 1);
        for (int i = 1; i <= 61; i++) begin
            if (i == 1)       cyc("dn1", 0, 1, 0, 0, 0, 0, 1, 1, 16'h5958, 1, 0);
            else if (i == 61) cyc("dn61", 0, 1, 0, 0, 0, 0, 1, 1, 16'h5858, 1, 0);
            else              cyc("dn_ro", 0, 1, 0, 0, 0, 0, 1, 0, 16'h0, 1, 0);
        end

        // 3: MIN_MAX=15 wrap and minute adjust below zero
        cur = 1;
        do_reset("b_reset");
        up_ticks("b_up", 599);
        cyc("b_10min", 0, 1, 0, 0, 0, 0, 0, 1, 16'h1000, 1, 0);
        up_ticks("b_up", 359);
        cyc("b_1559", 0, 0, 0, 0, 0, 0, 0, 1, 16'h1559, 1, 0);
        cyc("b_wrap", 0, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 1, 1);
        cyc("b_adj_min_dn", 0, 0, 1, 0, 1, 0, 1, 1, 16'h1500, 1, 0);
        cur = 0;

        // 4: seconds adjust has no carry; tick ignored in adjust mode
        do_reset("reset4");
        up_ticks("to_1259", 779);
        cyc("at_1259", 0, 0, 0, 0, 0, 0, 0, 1, 16'h1259, 1, 0);
        cyc("adj_sec_up", 0, 0, 1, 0, 1, 1, 0, 1, 16'h1200, 1, 0);
        cyc("adj_tick_ign", 0, 1, 0, 0, 1, 1, 0, 1, 16'h1200, 1, 0);
        cyc("adj_min_up", 0, 0, 1, 0, 1, 0, 0, 1, 16'h1300, 1, 0);
        cyc("adj_sec_dn", 0, 0, 1, 0, 1, 1, 1, 1, 16'h1359, 1, 0);

        // 5: pause with both enables, then normal mode with both enables
        for (int i = 0; i < 10; i++) cyc("pause_hold", 0, 1, 1, 1, 1, 1, 0, 1, 16'h1359, 1, 0);
        cyc("both_en1", 0, 1, 1, 0, 0, 1, 0, 1, 16'h1400, 1, 0);
        cyc("both_en2", 0, 1, 1, 0, 0, 1, 0, 1, 16'h1401, 1, 0);
        cyc("both_en3", 0, 1, 1, 0, 0, 1, 0, 1, 16'h1402, 1, 0);

        // 6: reset wins over a simultaneous tick
        do_reset("reset6");
        up_ticks("to_0733", 453);
        cyc("at_0733", 0, 0, 0, 0, 0, 0, 0, 1, 16'h0733, 1, 0);
        cyc("rst_tick", 1, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 1, 0);
        cyc("after_rst", 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 1, 0);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
